// File: rtl/hex_display.sv
// hex_display: bus-mapped six-digit seven-segment controller.
//
// Register map (addr[3:2]):
//   0 VALUE[23:0]   displayed value (hex nibbles, or binary in decimal mode)
//   1 MASK[5:0]     1 = digit on
//   2 BLINK[5:0]    1 = digit blinks
//   3 CTRL          bit0 enable, bit1 decimal, bit2 leading-zero suppress,
//                   bit8 busy (read-only, converter running)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   addr         byte address, only addr[3:2] decoded
//   wdata        write data
//   we           write enable, one word per cycle
//   rdata        registered read data, 1-cycle latency, read-before-write
//   rdata_valid  high every cycle after reset deasserts
//   hex0..hex5   active-low segments, bit0=a .. bit6=g, hex0 rightmost
//
// Decimal mode uses an iterative double-dabble converter: one shift/adjust
// iteration per cycle, 20 iterations, then the BCD result is committed.

module hex_display #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } conv_state_t;

    // Active-low segment pattern for one hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // One double-dabble iteration on {bcd[23:0], bin[19:0]}:
    // add 3 to every BCD nibble >= 5, then shift the whole register left.
    function automatic logic [43:0] dabble_step(input logic [43:0] sr);
        logic [43:0] adj;
        adj = sr;
        for (int k = 0; k < 6; k++) begin
            if (adj[20 + 4*k +: 4] >= 4'd5) begin
                adj[20 + 4*k +: 4] = adj[20 + 4*k +: 4] + 4'd3;
            end else begin
                adj[20 + 4*k +: 4] = adj[20 + 4*k +: 4];
            end
        end
        return {adj[42:0], 1'b0};
    endfunction

    // Architectural registers
    logic [23:0]      value_r;
    logic [5:0]       mask_r;
    logic [5:0]       blink_r;
    logic [2:0]       ctrl_r;

    // Converter state
    conv_state_t      state_r, state_nxt_s;
    logic [43:0]      sr_r, sr_nxt_s;
    logic [4:0]       iter_r, iter_nxt_s;
    logic             ovf_pend_r, ovf_pend_nxt_s;
    logic             commit_s;
    logic [43:0]      step_s;
    logic [23:0]      bcd_r;
    logic             overflow_r;

    // Blink timing
    logic [CNT_W-1:0] blink_cnt_r;
    logic             phase_r;

    // Bus decode
    logic             wr_value_s, wr_mask_s, wr_blink_s, wr_ctrl_s;
    logic             conv_trig_s;
    logic [19:0]      load_bin_s;
    logic             busy_s;
    logic [31:0]      rd_mux_s;

    // Display
    logic [5:0]       upper_zero_s;
    logic             zero_run_s;
    logic [6:0]       seg_nxt_s [6];

    logic             unused_s;
    assign unused_s = ^{addr[31:4], addr[1:0], wdata[31:24]};

    assign wr_value_s  = we & (addr[3:2] == 2'd0);
    assign wr_mask_s   = we & (addr[3:2] == 2'd1);
    assign wr_blink_s  = we & (addr[3:2] == 2'd2);
    assign wr_ctrl_s   = we & (addr[3:2] == 2'd3);
    // A VALUE write converts the freshly written data; a CTRL write that
    // selects decimal mode converts the value already held.
    assign conv_trig_s = wr_value_s | (wr_ctrl_s & wdata[1]);
    assign load_bin_s  = wr_value_s ? wdata[19:0] : value_r[19:0];
    assign busy_s      = (state_r == S_CONV);
    assign step_s      = dabble_step(sr_r);

    // Bus-writable registers
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= 24'd0;
            mask_r  <= 6'h3F;
            blink_r <= 6'd0;
            ctrl_r  <= 3'd0;
        end else begin
            if (wr_value_s) value_r <= wdata[23:0];
            if (wr_mask_s)  mask_r  <= wdata[5:0];
            if (wr_blink_s) blink_r <= wdata[5:0];
            if (wr_ctrl_s)  ctrl_r  <= wdata[2:0];
        end
    end

    // Converter next-state logic; a new trigger always restarts the conversion
    always_comb begin
        state_nxt_s    = state_r;
        sr_nxt_s       = sr_r;
        iter_nxt_s     = iter_r;
        ovf_pend_nxt_s = ovf_pend_r;
        commit_s       = 1'b0;
        if (conv_trig_s) begin
            state_nxt_s    = S_CONV;
            sr_nxt_s       = {24'd0, load_bin_s};
            iter_nxt_s     = 5'd0;
            ovf_pend_nxt_s = (load_bin_s > 20'd999999);
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_nxt_s = S_IDLE;
                end
                S_CONV: begin
                    sr_nxt_s   = step_s;
                    iter_nxt_s = iter_r + 5'd1;
                    if (iter_r == 5'd19) begin
                        state_nxt_s = S_IDLE;
                        commit_s    = 1'b1;
                    end else begin
                        state_nxt_s = S_CONV;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // Converter state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            sr_r       <= 44'd0;
            iter_r     <= 5'd0;
            ovf_pend_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sr_r       <= sr_nxt_s;
            iter_r     <= iter_nxt_s;
            ovf_pend_r <= ovf_pend_nxt_s;
        end
    end

    // Committed BCD result; the previous result stays visible while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_r      <= 24'd0;
            overflow_r <= 1'b0;
        end else if (commit_s) begin
            bcd_r      <= step_s[43:20];
            overflow_r <= ovf_pend_r;
        end
    end

    // Free-running blink counter; phase flips on every wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_r <= {CNT_W{1'b0}};
            phase_r     <= 1'b1;
        end else if (blink_cnt_r == CNT_MAX) begin
            blink_cnt_r <= {CNT_W{1'b0}};
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + CNT_W'(1'b1);
        end
    end

    // Read data selection
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr[3:2])
            2'd0:    rd_mux_s = {8'd0, value_r};
            2'd1:    rd_mux_s = {26'd0, mask_r};
            2'd2:    rd_mux_s = {26'd0, blink_r};
            2'd3:    rd_mux_s = {23'd0, busy_s, 5'd0, ctrl_r};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
        end else begin
            rdata       <= rd_mux_s;
            rdata_valid <= 1'b1;
        end
    end

    // upper_zero_s[i] is set when BCD digits i..5 are all zero
    always_comb begin
        upper_zero_s = 6'd0;
        zero_run_s   = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            zero_run_s      = zero_run_s & (bcd_r[4*i +: 4] == 4'd0);
            upper_zero_s[i] = zero_run_s;
        end
    end

    // Per-digit segment selection
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            seg_nxt_s[i] = SEG_BLANK;
            if (!(ctrl_r[0] & mask_r[i] & (~blink_r[i] | phase_r))) begin
                seg_nxt_s[i] = SEG_BLANK;
            end else if (ctrl_r[1]) begin
                if (overflow_r) begin
                    seg_nxt_s[i] = SEG_DASH;
                end else if (ctrl_r[2] && (i > 0) && upper_zero_s[i]) begin
                    seg_nxt_s[i] = SEG_BLANK;
                end else begin
                    seg_nxt_s[i] = seg_decode(bcd_r[4*i +: 4]);
                end
            end else begin
                seg_nxt_s[i] = seg_decode(value_r[4*i +: 4]);
            end
        end
    end

    // Registered segment outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            hex0 <= SEG_BLANK;
            hex1 <= SEG_BLANK;
            hex2 <= SEG_BLANK;
            hex3 <= SEG_BLANK;
            hex4 <= SEG_BLANK;
            hex5 <= SEG_BLANK;
        end else begin
            hex0 <= seg_nxt_s[0];
            hex1 <= seg_nxt_s[1];
            hex2 <= seg_nxt_s[2];
            hex3 <= seg_nxt_s[3];
            hex4 <= seg_nxt_s[4];
            hex5 <= seg_nxt_s[5];
        end
    end

endmodule

// File: tb/tb_hex_display.sv
// Directed testbench for hex_display (BLINK_DIV = 4).
module tb_hex_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int tests;
    int fails;

    // Reference blink phase: counter 0..3, phase flips on wrap, starts at 1
    logic [1:0] cnt_m;
    logic       ph_m;
    logic       ph_seen;

    hex_display #(.BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .hex0(hex0), .hex1(hex1), .hex2(hex2),
        .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            cnt_m <= 2'd0;
            ph_m  <= 1'b1;
        end else if (cnt_m == 2'd3) begin
            cnt_m <= 2'd0;
            ph_m  <= ~ph_m;
        end else begin
            cnt_m <= cnt_m + 2'd1;
        end
        ph_seen <= ph_m;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        tick();
        chk(tag, rdata, exp);
    endtask

    task automatic chk_all(input string tag, input logic [6:0] d5, input logic [6:0] d4,
                           input logic [6:0] d3, input logic [6:0] d2,
                           input logic [6:0] d1, input logic [6:0] d0);
        chk({tag, "_hex5"}, {25'd0, hex5}, {25'd0, d5});
        chk({tag, "_hex4"}, {25'd0, hex4}, {25'd0, d4});
        chk({tag, "_hex3"}, {25'd0, hex3}, {25'd0, d3});
        chk({tag, "_hex2"}, {25'd0, hex2}, {25'd0, d2});
        chk({tag, "_hex1"}, {25'd0, hex1}, {25'd0, d1});
        chk({tag, "_hex0"}, {25'd0, hex0}, {25'd0, d0});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;

        // 1. Reset state and register reads
        tick(); tick(); tick();
        chk("rst_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk_all("rst", SB, SB, SB, SB, SB, SB);
        reset = 1'b0;
        rd_chk("rd_value", 32'h0, 32'h0);
        chk("valid_after_rst", {31'd0, rdata_valid}, 32'd1);
        rd_chk("rd_mask",  32'h4, 32'h3F);
        rd_chk("rd_blink", 32'h8, 32'h0);
        rd_chk("rd_ctrl",  32'hC, 32'h0);
        chk_all("idle_blank", SB, SB, SB, SB, SB, SB);

        // 2. Hex mode
        wr(32'h0, 32'h00A5F0);
        wr(32'hC, 32'h1);
        tick();
        chk_all("hexmode", S0, S0, SA, S5, SF, S0);

        // 3. Decimal with suppression: 1234
        wr(32'hC, 32'h7);
        wr(32'h0, 32'd1234);
        addr = 32'hC;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 1)  chk("busy_first", rdata, 32'h107);
            if (k == 20) begin
                chk("busy_last", rdata, 32'h107);
                chk("old_bcd_hex0", {25'd0, hex0}, {25'd0, S0});
                chk("old_bcd_hex1", {25'd0, hex1}, {25'd0, SB});
            end
            if (k == 21) chk("busy_done", rdata, 32'h007);
        end
        chk_all("dec1234_lz", SB, SB, S1, S2, S3, S4);
        wr(32'hC, 32'h3);
        for (int k = 0; k < 21; k++) tick();
        chk_all("dec1234", S0, S0, S1, S2, S3, S4);

        // 4. Overflow, max value, restart mid-conversion
        wr(32'h0, 32'd1000000);
        for (int k = 0; k < 21; k++) tick();
        chk_all("overflow", SD, SD, SD, SD, SD, SD);
        wr(32'h0, 32'd999999);
        for (int k = 0; k < 21; k++) tick();
        chk_all("dec999999", S9, S9, S9, S9, S9, S9);
        wr(32'h0, 32'd123456);
        for (int k = 0; k < 9; k++) tick();
        wr(32'h0, 32'd7);
        addr = 32'hC;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 12) chk("restart_no_commit", {25'd0, hex0}, {25'd0, S9});
            if (k == 20) chk("restart_busy", rdata, 32'h103);
            if (k == 21) chk("restart_done", rdata, 32'h003);
        end
        chk_all("dec7", S0, S0, S0, S0, S0, S7);

        // 5. Blink in hex mode, then masked digit
        wr(32'hC, 32'h1);
        wr(32'h8, 32'h01);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("blink_hex0", {25'd0, hex0}, {25'd0, (ph_seen ? S7 : SB)});
            if (k % 4 == 0) chk("blink_hex1", {25'd0, hex1}, {25'd0, S0});
        end
        wr(32'h4, 32'h3E);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k > 0) chk("masked_hex0", {25'd0, hex0}, {25'd0, SB});
        end
        chk("masked_hex1", {25'd0, hex1}, {25'd0, S0});

        // 6. Reset mid-conversion, read-before-write
        wr(32'h8, 32'h0);
        wr(32'h4, 32'h3F);
        wr(32'hC, 32'h3);
        for (int k = 0; k < 25; k++) tick();
        chk("pre_rst_dec7", {25'd0, hex0}, {25'd0, S7});
        wr(32'h0, 32'd42);
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        chk_all("midconv_rst", SB, SB, SB, SB, SB, SB);
        chk("midconv_rst_valid", {31'd0, rdata_valid}, 32'd0);
        reset = 1'b0;
        rd_chk("rst_busy_clear", 32'hC, 32'h0);
        wr(32'hC, 32'h3);
        tick();
        chk_all("bcd_cleared", S0, S0, S0, S0, S0, S0);
        addr  = 32'h4;
        wdata = 32'h15;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        chk("rbw_old_mask", rdata, 32'h3F);
        tick();
        chk("rbw_new_mask", rdata, 32'h15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_display.md
Name: hex_display

Overview:
- Bus-mapped six-digit seven-segment controller that drives hex0..hex5 on the DE1-SoC top.
- It is decoded off the data bus alongside RAM, GPIO and the graphics card, and is written by the DLX with word accesses.
- Hex mode shows VALUE nibbles directly.
- Decimal mode runs an iterative binary-to-BCD converter (double dabble). It also supports per-digit masking, per-digit blinking and leading-zero suppression.

Parameters:
- BLINK_DIV, 25000000: clock cycles per blink half-period (0.5 s at 50 MHz). Minimum 2.

Ports:
- clk  in  1  system clock (clock_50)
- reset  in  1  synchronous, active-high reset
- addr  in  32  byte address from bus; only addr[3:2] decoded
- wdata  in  32  write data
- we  in  1  write enable, one word per cycle
- rdata  out  32  registered read data
- rdata_valid  out  1  read data valid
- hex0..hex5  out  7 each  segments, active-low, bit0=a .. bit6=g; hex0 is the rightmost/least significant digit

Behaviour:
- Register map (addr[3:2]):
  - 0 VALUE[23:0]
  - 1 MASK[5:0] (1 = digit on)
  - 2 BLINK[5:0] (1 = digit blinks)
  - 3 CTRL: bit0 enable, bit1 decimal mode, bit2 leading-zero suppress; bit8 busy (read-only)
  - Unused bits read 0.
- Reset values: VALUE=0, MASK=6'h3F, BLINK=0, CTRL=0, busy=0, bcd=0, overflow=0, blink counter=0, phase=1, rdata=0, rdata_valid=0, all hex outputs 7'h7F (blank).
- Write: takes effect at the clock edge where we=1.
- Read: rdata registered from addr every cycle, 1-cycle latency, read-before-write (same-cycle write returns old value). rdata_valid=0 during reset, then 1 every cycle from the first edge after reset deasserts.
- Segment decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - dash=0111111, blank=1111111
- Blink: counter runs 0..BLINK_DIV-1 continuously; on wrap, phase toggles. A BLINK write does not reset the counter.
- Digit i visible = CTRL.enable & MASK[i] & (~BLINK[i] | phase). Invisible digits output blank.
- Output timing: hex outputs are registered and reflect register/phase state one cycle after it changes.
- Hex mode: digit i shows VALUE[4i+3:4i].
- Decimal mode: digit i shows bcd[4i+3:4i].
  - Overflow: if overflow=1, every visible digit shows dash.
  - Leading-zero suppression: with CTRL bit2=1, leading zero digits above digit 0 are blank. Digit 0 is never suppressed.
- Converter FSM, states IDLE and CONV:
  - Trigger: a VALUE write, or a CTRL write that sets decimal=1.
  - On trigger: load shift register with VALUE[19:0] (new write data); overflow_pending = (value > 999999); iteration count=0; busy=1; go to CONV.
  - Each CONV cycle performs one iteration: add 3 to every BCD nibble >=5, then shift left by 1.
  - After the 20th iteration (20 cycles in CONV), at that edge: bcd <= result, overflow <= overflow_pending, busy=0, return to IDLE.
  - Display updates one cycle later, i.e. 21 cycles after the write edge.
  - Old bcd stays displayed while busy.
  - Trigger during CONV: restart from the new value. Any partial result is discarded.
  - Reset mid-conversion: abort; bcd=0, busy=0.
  - Clearing decimal mid-conversion: no abort. The result is still committed, and hex mode displays immediately.
- VALUE[23:20] are ignored in decimal mode.

Test Plan:
1. Reset, then read all 4 addresses -> rdata 0, 0x3F, 0, 0; rdata_valid=1; hex0..5=7'h7F.
2. Write VALUE=0x00A5F0, CTRL=1 -> hex0=1000000, hex1=0001110, hex2=0010010, hex3=0001000, hex4=hex5=1000000.
3. Write CTRL=0x7, VALUE=1234 -> CTRL bit8 reads 1 for 20 cycles; 21 cycles after the write: hex3..0 show 1,2,3,4 and hex5,hex4=blank. Same with CTRL=0x3 -> hex5,hex4 show 0.
4. Decimal, VALUE=1000000 -> all six digits 0111111. VALUE=999999 -> all digits 0010000. Rewrite VALUE=7 at cycle 10 of the conversion -> busy until 20 cycles after the rewrite, final hex0=1111000.
5. BLINK_DIV=4, BLINK=6'h01, hex mode -> hex0 toggles between decoded digit and blank every 4 cycles; others steady. MASK=0x3E -> hex0 stays blank.
6. Assert reset at conversion cycle 5 -> busy=0, bcd=0, all outputs 7'h7F next cycle. A read with a simultaneous MASK write -> old MASK returned, new MASK on the next read.
